// File: rtl/mem_access_ctrl_if.sv
// Signal bundle joining the memory-stage controller to the EX/Mem register and Dcache.
// master is the controller (initiator of the Dcache port); slave is the pipeline/Dcache side.
interface mem_access_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  EXMem_MemEN;
  logic                  EXMem_MemRd;
  logic [1:0]            EXMem_MemWidth;
  logic                  EXMem_MemSign;
  logic [ADDR_WIDTH-1:0] EXMem_Addr;
  logic [DATA_WIDTH-1:0] EXMem_Rs2Data;
  logic [DATA_WIDTH-1:0] Dcache_DataRd;
  logic                  Mem_DcacheEN;
  logic                  Mem_DcacheRd;
  logic                  Mem_DcacheSign;
  logic [1:0]            Mem_DcacheWidth;
  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr;
  logic [DATA_WIDTH-1:0] Mem_DcacheWData;
  logic [DATA_WIDTH-1:0] Mem_LoadData;
  logic                  Mem_LoadValid;
  logic                  Mem_Stall;
  logic                  Mem_AccessErr;
  logic [CNT_WIDTH-1:0]  Mem_MisalignCnt;

  modport master (
    input  EXMem_MemEN, EXMem_MemRd, EXMem_MemWidth, EXMem_MemSign, EXMem_Addr,
           EXMem_Rs2Data, Dcache_DataRd,
    output Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheSign, Mem_DcacheWidth, Mem_DcacheAddr,
           Mem_DcacheWData, Mem_LoadData, Mem_LoadValid, Mem_Stall, Mem_AccessErr,
           Mem_MisalignCnt
  );

  modport slave (
    output EXMem_MemEN, EXMem_MemRd, EXMem_MemWidth, EXMem_MemSign, EXMem_Addr,
           EXMem_Rs2Data, Dcache_DataRd,
    input  Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheSign, Mem_DcacheWidth, Mem_DcacheAddr,
           Mem_DcacheWData, Mem_LoadData, Mem_LoadValid, Mem_Stall, Mem_AccessErr,
           Mem_MisalignCnt
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: aligned accesses pass through in the same cycle,
// misaligned halves/words are split into byte accesses while the pipeline is stalled.
module mem_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.master bus
);
  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t                r_state;
  logic [1:0]            r_idx;
  logic [23:0]           r_lbuf;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_width;
  logic                  r_rd;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_illegal;
  logic                  w_aligned;
  logic                  w_misalign;
  logic [1:0]            w_last_idx;
  logic                  w_split_last;
  logic [7:0]            w_rbyte;
  logic [7:0]            w_wbyte;
  logic [DATA_WIDTH-1:0] w_split_ld;

  function automatic logic [DATA_WIDTH-1:0] f_ext_half(input logic [15:0] h, input logic sgn);
    f_ext_half = {{(DATA_WIDTH-16){sgn & h[15]}}, h};
  endfunction

  assign w_illegal  = (bus.EXMem_MemWidth == 2'b11);
  assign w_aligned  = (bus.EXMem_MemWidth == 2'b00) ||
                      ((bus.EXMem_MemWidth == 2'b01) && !bus.EXMem_Addr[0]) ||
                      ((bus.EXMem_MemWidth == 2'b10) && (bus.EXMem_Addr[1:0] == 2'b00));
  assign w_misalign = bus.EXMem_MemEN && !w_illegal && !w_aligned;

  assign w_last_idx   = (r_width == 2'b01) ? 2'd1 : 2'd3;
  assign w_split_last = (r_state == S_SPLIT) && (r_idx == w_last_idx);
  assign w_rbyte      = bus.Dcache_DataRd[7:0];
  assign w_wbyte      = 8'(r_wdata >> {r_idx, 3'b000});
  // The final byte comes straight from Dcache; earlier bytes were collected in r_lbuf.
  assign w_split_ld   = (r_width == 2'b01) ? f_ext_half({w_rbyte, r_lbuf[7:0]}, r_sign)
                                           : DATA_WIDTH'({w_rbyte, r_lbuf});

  assign bus.Mem_MisalignCnt = rst_n ? r_cnt : '0;

  always_comb begin
    bus.Mem_DcacheEN    = 1'b0;
    bus.Mem_DcacheRd    = 1'b0;
    bus.Mem_DcacheSign  = 1'b0;
    bus.Mem_DcacheWidth = 2'b00;
    bus.Mem_DcacheAddr  = '0;
    bus.Mem_DcacheWData = '0;
    bus.Mem_LoadData    = '0;
    bus.Mem_LoadValid   = 1'b0;
    bus.Mem_Stall       = 1'b0;
    bus.Mem_AccessErr   = 1'b0;
    if (rst_n) begin
      if (r_state == S_SPLIT) begin
        bus.Mem_DcacheEN    = 1'b1;
        bus.Mem_DcacheRd    = r_rd;
        bus.Mem_DcacheAddr  = r_addr + ADDR_WIDTH'(r_idx);
        bus.Mem_DcacheWData = DATA_WIDTH'(w_wbyte);
        bus.Mem_Stall       = !w_split_last;
        if (w_split_last && r_rd) begin
          bus.Mem_LoadData  = w_split_ld;
          bus.Mem_LoadValid = 1'b1;
        end
      end else if (bus.EXMem_MemEN) begin
        if (w_illegal) begin
          bus.Mem_AccessErr = 1'b1;
        end else if (w_aligned) begin
          bus.Mem_DcacheEN    = 1'b1;
          bus.Mem_DcacheRd    = bus.EXMem_MemRd;
          bus.Mem_DcacheSign  = bus.EXMem_MemSign;
          bus.Mem_DcacheWidth = bus.EXMem_MemWidth;
          bus.Mem_DcacheAddr  = bus.EXMem_Addr;
          bus.Mem_DcacheWData = bus.EXMem_Rs2Data;
          if (bus.EXMem_MemRd) begin
            bus.Mem_LoadData  = bus.Dcache_DataRd;
            bus.Mem_LoadValid = 1'b1;
          end
        end else begin
          bus.Mem_DcacheEN    = 1'b1;
          bus.Mem_DcacheRd    = bus.EXMem_MemRd;
          bus.Mem_DcacheAddr  = bus.EXMem_Addr;
          bus.Mem_DcacheWData = DATA_WIDTH'(bus.EXMem_Rs2Data[7:0]);
          bus.Mem_Stall       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_lbuf  <= '0;
      r_addr  <= '0;
      r_width <= 2'b00;
      r_rd    <= 1'b0;
      r_sign  <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_misalign) begin
            r_state <= S_SPLIT;
            r_idx   <= 2'd1;
            r_addr  <= bus.EXMem_Addr;
            r_width <= bus.EXMem_MemWidth;
            r_rd    <= bus.EXMem_MemRd;
            r_sign  <= bus.EXMem_MemSign;
            r_wdata <= bus.EXMem_Rs2Data;
            r_lbuf  <= {16'h0000, w_rbyte};
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
          end
        end
        S_SPLIT: begin
          // EXMem inputs are deliberately ignored here: a started split always completes.
          case (r_idx)
            2'd1:    r_lbuf[15:8]  <= w_rbyte;
            2'd2:    r_lbuf[23:16] <= w_rbyte;
            default: ;
          endcase
          if (w_split_last) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
          end else begin
            r_idx   <= r_idx + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage access controller. It sits between the EX/Mem pipeline register and `Dcache` and is the initiator side of the Dcache port. Aligned loads and stores pass straight through in the same cycle. Misaligned halfword and word accesses are split into sequential byte accesses, with the pipeline stalled until the access completes. Results are sign- or zero-extended, and misaligned traffic is counted for performance monitoring.

## Interface
- `ADDR_WIDTH`, default 32: byte address width (`ADDR_WIDTH` macro).
- `DATA_WIDTH`, default 32: data width (`DATA_WIDTH` macro).
- `CNT_WIDTH`, default 16: width of the misalignment counter.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset. Sampled on `posedge clk`.
- `EXMem_MemEN` in 1: memory access request.
- `EXMem_MemRd` in 1: 1 = load, 0 = store.
- `EXMem_MemWidth` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `EXMem_MemSign` in 1: sign-extend the load result.
- `EXMem_Addr` in ADDR_WIDTH: byte address.
- `EXMem_Rs2Data` in DATA_WIDTH: store data.
- `Dcache_DataRd` in DATA_WIDTH: combinational read data from Dcache.
- `Mem_DcacheEN`, `Mem_DcacheRd`, `Mem_DcacheSign` out 1: Dcache request controls.
- `Mem_DcacheWidth` out 2: Dcache access width.
- `Mem_DcacheAddr` out ADDR_WIDTH: Dcache byte address.
- `Mem_DcacheWData` out DATA_WIDTH: Dcache store data.
- `Mem_LoadData` out DATA_WIDTH: final extended load result.
- `Mem_LoadValid` out 1: `Mem_LoadData` is valid this cycle.
- `Mem_Stall` out 1: holds the IF to Mem stages.
- `Mem_AccessErr` out 1: one-cycle pulse on an illegal width.
- `Mem_MisalignCnt` out CNT_WIDTH: saturating count of split accesses.

## Operation
- Alignment: byte accesses are always aligned. A half is aligned iff `addr[0]==0`. A word is aligned iff `addr[1:0]==0`.
- States: IDLE and SPLIT. A 2-bit index `idx` and a latched request (addr, width, rd, sign, wdata) are registered. A 24-bit byte buffer `lbuf` collects load bytes.
- IDLE, aligned legal request:
  - Drive the Dcache outputs combinationally from the EXMem inputs: width unchanged, `Mem_DcacheWData` = `EXMem_Rs2Data`.
  - For a load, `Mem_LoadData` = `Dcache_DataRd` and `Mem_LoadValid`=1.
  - `Mem_Stall`=0. State stays IDLE.
- IDLE, misaligned legal request:
  - N = 2 for a half, N = 4 for a word.
  - Issue byte 0: width 00, sign 0, address `EXMem_Addr`. For a store, `WData[7:0]`=`Rs2Data[7:0]`.
  - Latch the request and `lbuf[7:0]`=`Dcache_DataRd[7:0]`.
  - Set `idx`=1, assert `Mem_Stall`, go to SPLIT.
  - Increment `Mem_MisalignCnt`, saturating at all-ones.
- SPLIT:
  - Issue byte `idx` at latched addr + `idx`; the address wraps modulo 2^ADDR_WIDTH. Byte accesses may cross a word boundary.
  - Store data is latched `wdata[8*idx+:8]`. Load data goes to `lbuf[8*idx+:8]`.
  - When `idx`<N-1: `Mem_Stall`=1, `idx`++.
  - When `idx`==N-1: `Mem_Stall`=0. For a load, `Mem_LoadData` = extend({`Dcache_DataRd[7:0]`, `lbuf`[8*(N-1)-1:0]}) and `Mem_LoadValid`=1. Return to IDLE.
  - EXMem inputs are ignored in SPLIT, including a dropped `EXMem_MemEN`. The split always completes.
- Extension rule for halves: sign → bits [31:16] = bit15; unsigned → zero. Words are not extended.
- Width 11 with `EXMem_MemEN`: no Dcache enable, `Mem_AccessErr`=1 for that cycle, `Mem_LoadData`=0, no stall.
- No request: all Dcache outputs are 0. `Mem_LoadData`=0, `Mem_LoadValid`=0.

## Timing
- Reset values, for the cycle after `rst_n` is sampled low: state IDLE, `idx`=0, `lbuf`=0, latched request=0, `Mem_MisalignCnt`=0.
- While `rst_n` is low, all outputs are forced to 0 combinationally.
- Reset mid-SPLIT abandons the split. Bytes already stored stay written. No `Mem_LoadValid` is produced.
- Aligned access latency is 0: same cycle, no stall.
- Misaligned half: 2 cycles, stall high in cycle 0. Misaligned word: 4 cycles, stall high in cycles 0–2.
- Result and `Mem_LoadValid` appear in the last cycle, with stall low.
- The pipeline must hold the EXMem inputs while `Mem_Stall`=1. A new request is accepted in the cycle after the last split cycle.

## Test plan
- Aligned store word 0x11223344 to 0x100, then load word from 0x100 → Dcache written the same cycle; load returns 0x11223344 in 0 cycles; `Mem_Stall` never 1; count stays 0.
- Misaligned store word 0xAABBCCDD to 0x102 → byte writes 0xDD@0x102, 0xCC@0x103, 0xBB@0x104, 0xAA@0x105 in 4 consecutive cycles; stall 1,1,1,0; count=1.
- Misaligned signed load half from 0x103 after bytes 0x80@0x103, 0xFF@0x104 → cycle 1 `Mem_LoadData`=0xFFFFFF80, valid=1. The same load unsigned returns 0x0000FF80.
- Misaligned word load from 0x102 after the scenario-2 store, with `EXMem_MemEN` dropped in cycle 1 → returns 0xAABBCCDD in cycle 3.
- Width 11 request → `Mem_AccessErr` pulses for 1 cycle; `Mem_DcacheEN`=0; no stall.
- `rst_n` low in cycle 1 of a word split → the next cycle is IDLE with stall 0; a following aligned load works normally.
- Saturation: preload `Mem_MisalignCnt` to 0xFFFF, then perform one more misaligned access → counter remains 0xFFFF.
